// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: master-end controller for a cascaded BCD countdown chain.
// Issues the reload and paced decrement strobes and reports run/pause/timeout status.
module game_timer_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26,
  parameter int TCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              zero_in,
  output logic              reconfig,
  output logic              bdn,
  output logic              time_up,
  output logic              running,
  output logic              paused,
  output logic [TCNT_W-1:0] tick_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]  PRESC_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] TICK_SAT  = {TCNT_W{1'b1}};

  state_t              state_r;
  state_t              state_next_s;
  logic [CNT_W-1:0]    presc_r;
  logic [TCNT_W-1:0]   tick_r;
  logic                armed_r;
  logic                bdn_r;
  logic                start_q_r;
  logic                pause_q_r;
  logic                start_en_r;
  logic                pause_en_r;
  logic                start_rise_s;
  logic                pause_rise_s;
  logic                advance_s;
  logic                wrap_s;

  // The enables stay low until an input is seen low, so a level held through reset is not an edge.
  assign start_rise_s = start & ~start_q_r & start_en_r;
  assign pause_rise_s = pause & ~pause_q_r & pause_en_r;
  assign advance_s    = (state_r == RUN) && (state_next_s == RUN);
  assign wrap_s       = advance_s && (presc_r == PRESC_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode with restart > timeout > pause priority in RUN.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_rise_s) state_next_s = LOAD;
        else              state_next_s = IDLE;
      end
      LOAD: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (start_rise_s)              state_next_s = LOAD;
        else if (zero_in && armed_r)   state_next_s = DONE;
        else if (pause_rise_s)         state_next_s = PAUSE;
        else                           state_next_s = RUN;
      end
      PAUSE: begin
        if (start_rise_s)      state_next_s = LOAD;
        else if (pause_rise_s) state_next_s = RUN;
        else                   state_next_s = PAUSE;
      end
      DONE: begin
        if (start_rise_s) state_next_s = LOAD;
        else              state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Edge-detect history, prescaler, strobe counter and the registered decrement pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q_r  <= 1'b0;
      pause_q_r  <= 1'b0;
      start_en_r <= 1'b0;
      pause_en_r <= 1'b0;
      presc_r    <= {CNT_W{1'b0}};
      tick_r     <= {TCNT_W{1'b0}};
      armed_r    <= 1'b0;
      bdn_r      <= 1'b0;
    end else begin
      start_q_r <= start;
      pause_q_r <= pause;
      if (!start) start_en_r <= 1'b1;
      if (!pause) pause_en_r <= 1'b1;
      if (state_next_s == LOAD) begin
        presc_r <= {CNT_W{1'b0}};
        tick_r  <= {TCNT_W{1'b0}};
        armed_r <= 1'b0;
        bdn_r   <= 1'b0;
      end else if (wrap_s) begin
        presc_r <= {CNT_W{1'b0}};
        armed_r <= 1'b1;
        bdn_r   <= 1'b1;
        if (tick_r != TICK_SAT) tick_r <= tick_r + {{(TCNT_W-1){1'b0}}, 1'b1};
      end else begin
        bdn_r <= 1'b0;
        if (advance_s) presc_r <= presc_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Moore status decode.
  always_comb begin
    reconfig = 1'b0;
    running  = 1'b0;
    paused   = 1'b0;
    time_up  = 1'b0;
    case (state_r)
      LOAD:    reconfig = 1'b1;
      RUN:     running  = 1'b1;
      PAUSE:   paused   = 1'b1;
      DONE:    time_up  = 1'b1;
      default: reconfig = 1'b0;
    endcase
  end

  assign bdn        = bdn_r;
  assign tick_count = tick_r;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: one digit of the chain is modelled in the bench,
// and a rule-level reference model predicts every output cycle by cycle.
module tb_game_timer_ctrl;

  localparam int TD = 4;
  localparam int TW = 4;
  localparam int IDLE = 0, LOAD = 1, RUN = 2, PAUSE = 3, DONE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          zero_in = 1'b0;
  logic          reconfig, bdn, time_up, running, paused;
  logic [TW-1:0] tick_count;
  logic [8:0]    dut_vec;

  int checks = 0;
  int errors = 0;

  int digit   = 0;
  bit force_z = 1'b0;
  bit no_z    = 1'b0;

  int m_st = IDLE, m_presc = 0, m_tick = 0;
  bit m_armed = 1'b0, m_bdn = 1'b0, m_sq = 1'b0, m_pq = 1'b0, m_sen = 1'b0, m_pen = 1'b0;

  game_timer_ctrl #(.TICK_DIV(TD), .CNT_W(3), .TCNT_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .zero_in(zero_in),
    .reconfig(reconfig), .bdn(bdn), .time_up(time_up), .running(running),
    .paused(paused), .tick_count(tick_count)
  );

  assign dut_vec = {reconfig, bdn, time_up, running, paused, tick_count};

  always #5 clk = ~clk;

  function automatic logic [8:0] exp_vec();
    return {m_st == LOAD, m_bdn, m_st == DONE, m_st == RUN, m_st == PAUSE, TW'(m_tick)};
  endfunction

  // One clock: drive inputs mid-cycle, advance the digit and the reference model, return #1 after the edge.
  task automatic cycle(input logic s, input logic p, input logic r);
    bit sr, pr;
    int nst, nxt_digit;
    @(negedge clk);
    start   = s;
    pause   = p;
    rst     = r;
    zero_in = force_z | (!no_z && digit == 0);
    nxt_digit = digit;
    if (reconfig) nxt_digit = 9;
    else if (bdn) nxt_digit = (digit == 0) ? 9 : digit - 1;
    sr = s && !m_sq && m_sen;
    pr = p && !m_pq && m_pen;
    if (!r) begin
      m_st = IDLE; m_presc = 0; m_tick = 0; m_armed = 0; m_bdn = 0;
      m_sq = 0; m_pq = 0; m_sen = 0; m_pen = 0;
    end else begin
      nst   = m_st;
      m_bdn = 0;
      case (m_st)
        IDLE: if (sr) nst = LOAD;
        LOAD: nst = RUN;
        RUN: begin
          if (sr) nst = LOAD;
          else if (zero_in && m_armed) nst = DONE;
          else if (pr) nst = PAUSE;
          else if (m_presc == TD - 1) begin
            m_presc = 0; m_bdn = 1; m_armed = 1;
            if (m_tick < 2**TW - 1) m_tick++;
          end else m_presc++;
        end
        default: begin
          if (sr) nst = LOAD;
          else if (pr && m_st == PAUSE) nst = RUN;
        end
      endcase
      if (nst == LOAD) begin m_presc = 0; m_tick = 0; m_armed = 0; end
      m_st = nst;
      m_sq = s; m_pq = p;
      if (!s) m_sen = 1;
      if (!p) m_pen = 1;
    end
    @(posedge clk);
    #1;
    digit = nxt_digit;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec !== 9'd0) begin errors++; $display("FAIL reset_outputs got %b exp %b", dut_vec, 9'd0); end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      checks++;
      if (reconfig !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL held_start_no_load got %b exp %b", dut_vec, exp_vec());
      end
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (reconfig !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL load_after_new_edge got %b exp %b", dut_vec, exp_vec());
    end
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_countdown();
    int n_rec, n_bdn, last, run0, cyc;
    n_rec = 0; n_bdn = 0; last = -1; run0 = -1;
    cycle(1'b1, 1'b0, 1'b1);
    if (reconfig) n_rec++;
    for (cyc = 1; cyc < 100 && m_st != DONE; cyc++) begin
      cycle(1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL countdown_vec got %b exp %b", dut_vec, exp_vec()); end
      if (reconfig) n_rec++;
      if (run0 < 0 && running) run0 = cyc;
      if (bdn) begin
        checks++;
        if (cyc - ((n_bdn == 0) ? run0 : last) != TD) begin
          errors++; $display("FAIL bdn_spacing got %0d exp %0d", cyc - ((n_bdn == 0) ? run0 : last), TD);
        end
        last = cyc; n_bdn++;
      end
    end
    checks++;
    if (m_st != DONE) begin errors++; $display("FAIL countdown_timeout got state %0d exp %0d", m_st, DONE); end
    checks++;
    if (n_rec != 1 || n_bdn != 9) begin errors++; $display("FAIL pulse_counts got rec=%0d bdn=%0d exp rec=1 bdn=9", n_rec, n_bdn); end
    checks++;
    if (time_up !== 1'b1 || running !== 1'b0 || tick_count !== 4'd9) begin
      errors++; $display("FAIL done_status got %b exp time_up=1 running=0 tick=9", dut_vec);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      checks++;
      if (bdn !== 1'b0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL no_tenth_bdn got %b exp %b", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_pause();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50 && !(m_st == RUN && m_presc == 2 && m_tick >= 1); i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (paused !== 1'b1 || dut_vec !== exp_vec()) begin errors++; $display("FAIL enter_pause got %b exp %b", dut_vec, exp_vec()); end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      checks++;
      if (bdn !== 1'b0 || paused !== 1'b1 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL pause_hold got %b exp %b", dut_vec, exp_vec());
      end
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL resume got running=%b exp 1", running); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (bdn !== 1'b0) begin errors++; $display("FAIL resume_plus1 got bdn=%b exp 0", bdn); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (bdn !== 1'b1 || dut_vec !== exp_vec()) begin errors++; $display("FAIL resume_plus2 got %b exp %b", dut_vec, exp_vec()); end
  endtask

  task automatic test_restart();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50 && m_tick < 2; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if (reconfig !== 1'b1 || tick_count !== 4'd0 || paused !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL restart_wins got %b exp %b", dut_vec, exp_vec());
    end
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stale_zero();
    force_z = 1'b1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !m_bdn; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      checks++;
      if (running !== 1'b1 || dut_vec !== exp_vec()) begin errors++; $display("FAIL stale_zero_run got %b exp %b", dut_vec, exp_vec()); end
    end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_up !== 1'b1 || dut_vec !== exp_vec()) begin errors++; $display("FAIL armed_zero_done got %b exp %b", dut_vec, exp_vec()); end
    force_z = 1'b0;
  endtask

  task automatic test_saturate();
    no_z = 1'b1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 90; i++) cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (tick_count !== 4'hF || dut_vec !== exp_vec()) begin errors++; $display("FAIL tick_saturate got %b exp %b", dut_vec, exp_vec()); end
    no_z = 1'b0;
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !m_bdn; i++) cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (bdn !== 1'b1) begin errors++; $display("FAIL pre_reset_bdn got %b exp 1", bdn); end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_vec !== 9'd0) begin errors++; $display("FAIL mid_reset got %b exp %b", dut_vec, 9'd0); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (reconfig !== 1'b0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL post_reset_idle got %b exp %b", dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    logic s, p, r, prev_bdn;
    s = 1'b0; p = 1'b0; prev_bdn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 47) == 0) s = ~s;
      if ($urandom_range(0, 11) == 0) p = ~p;
      if ($urandom_range(0, 39) == 0) force_z = ~force_z;
      r = ($urandom_range(0, 299) != 0);
      cycle(s, p, r);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_vec cyc %0d got %b exp %b", i, dut_vec, exp_vec()); end
      if ((bdn && prev_bdn) || (bdn && !running)) begin
        errors++; $display("FAIL bdn_rule cyc %0d got bdn=%b prev=%b running=%b", i, bdn, prev_bdn, running);
      end
      prev_bdn = bdn;
    end
    force_z = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_restart();
    test_stale_zero();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
